// File: rtl/sync_pkg.sv
// sync_pkg -- shared constants and helpers for the sync_filt block.
//
// Contents:
//   STAGES_MIN / STAGES_MAX     legal synchronizer depth range
//   FILT_CYC_MIN / FILT_CYC_MAX legal debounce length range
//   cnt_width()                 debounce counter width for a given length
package sync_pkg;

  localparam int STAGES_MIN   = 2;
  localparam int STAGES_MAX   = 4;
  localparam int FILT_CYC_MIN = 1;
  localparam int FILT_CYC_MAX = 255;

  // The counter only ever reaches FILT_CYC_P-1, but sizing for FILT_CYC_P
  // keeps FILT_CYC_P=1 at a legal one-bit width.
  function automatic int cnt_width(input int filt_cyc);
    return $clog2(filt_cyc + 1);
  endfunction

endpackage

// File: rtl/sync_filt_bit.sv
// sync_filt_bit -- one channel of the sync_filt block: debounce counter,
// filtered level register and registered rise/fall edge pulses.
//
// Build option: SYNC_FILT_DEBOUNCE_EN
//   defined   -> level toggles only after the synchronized input has
//                differed from it for FILT_CYC_P consecutive cycles
//   undefined -> no counter; level registers the synchronized input
//                (one-cycle latency), busy_o tied low
//
// Ports:
//   clk_i    clock, rising edge
//   rstn_i   asynchronous active-low reset
//   sync_i   synchronized channel input
//   level_o  filtered channel level
//   rise_o   one-cycle pulse on level_o 0->1
//   fall_o   one-cycle pulse on level_o 1->0
//   busy_o   debounce counter nonzero
module sync_filt_bit
  import sync_pkg::*;
#(
  parameter int   FILT_CYC_P  = 4,
  parameter logic RESET_VAL_P = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic sync_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  if (FILT_CYC_P < FILT_CYC_MIN || FILT_CYC_P > FILT_CYC_MAX) begin : g_bad_filt
    $error("sync_filt_bit: FILT_CYC_P=%0d outside %0d..%0d",
           FILT_CYC_P, FILT_CYC_MIN, FILT_CYC_MAX);
  end

  logic diff;
  logic fire;

  assign diff = sync_i ^ level_o;

`ifdef SYNC_FILT_DEBOUNCE_EN
  localparam int               CNT_W  = cnt_width(FILT_CYC_P);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILT_CYC_P - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal count reached while still differing: toggle now. Because the
  // counter clears on fire, it can never pass CNT_TC and never wraps.
  assign fire = diff && (cnt_q == CNT_TC);

  always_comb begin
    cnt_d = '0;
    if (diff && !fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = |cnt_q;
`else
  assign fire   = diff;
  assign busy_o = 1'b0;
`endif

  // Edge pulses come from the pre-toggle level, so rise and fall are
  // mutually exclusive and line up with the level_o change.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      level_o <= RESET_VAL_P;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      rise_o <= fire & ~level_o;
      fall_o <= fire &  level_o;
      if (fire) begin
        level_o <= ~level_o;
      end
    end
  end

endmodule

// File: rtl/sync_filt.sv
// sync_filt -- multi-channel asynchronous input synchronizer with per-channel
// debounce filter and edge detection.
//
// Build option: SYNC_FILT_DEBOUNCE_EN (see sync_filt_bit). When undefined,
// level_o simply registers sync_o and busy_o is constant 0.
//
// Ports:
//   clk_i    sole clock, rising edge
//   rstn_i   asynchronous active-low reset
//   async_i  [WIDTH_P] asynchronous channel inputs
//   sync_o   [WIDTH_P] last synchronizer stage
//   level_o  [WIDTH_P] filtered, registered channel levels
//   rise_o   [WIDTH_P] one-cycle pulse per channel on level 0->1
//   fall_o   [WIDTH_P] one-cycle pulse per channel on level 1->0
//   busy_o   any channel debounce counter nonzero
module sync_filt
  import sync_pkg::*;
#(
  parameter int                 WIDTH_P     = 8,
  parameter int                 STAGES_P    = 2,
  parameter logic [WIDTH_P-1:0] RESET_VAL_P = '0,
  parameter int                 FILT_CYC_P  = 4
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [WIDTH_P-1:0] async_i,
  output logic [WIDTH_P-1:0] sync_o,
  output logic [WIDTH_P-1:0] level_o,
  output logic [WIDTH_P-1:0] rise_o,
  output logic [WIDTH_P-1:0] fall_o,
  output logic               busy_o
);

  if (STAGES_P < STAGES_MIN || STAGES_P > STAGES_MAX) begin : g_bad_stages
    $error("sync_filt: STAGES_P=%0d outside %0d..%0d",
           STAGES_P, STAGES_MIN, STAGES_MAX);
  end

  // Stage 0 is the metastability-catching flop; only the last stage is used.
  logic [STAGES_P-1:0][WIDTH_P-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= {STAGES_P{RESET_VAL_P}};
    end else begin
      sync_q[0] <= async_i;
      for (int s = 1; s < STAGES_P; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_o = sync_q[STAGES_P-1];

  logic [WIDTH_P-1:0] busy_vec;

  for (genvar i = 0; i < WIDTH_P; i++) begin : g_ch
    sync_filt_bit #(
      .FILT_CYC_P  (FILT_CYC_P),
      .RESET_VAL_P (RESET_VAL_P[i])
    ) u_bit (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .sync_i  (sync_o[i]),
      .level_o (level_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i]),
      .busy_o  (busy_vec[i])
    );
  end

  assign busy_o = |busy_vec;

endmodule

// File: doc/sync_filt.md
SYNC_FILT -- requirements
Module: sync_filt

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8: number of independent single-bit channels.
REQ-002 SHALL have parameter STAGES_P, default 2: synchronizer flop depth; legal range 2..4.
REQ-003 SHALL have parameter RESET_VAL_P, default '0: per-channel reset value, WIDTH_P bits.
REQ-004 SHALL have parameter FILT_CYC_P, default 4: debounce length in cycles; legal range 1..255.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port async_i  input  WIDTH_P  asynchronous channel inputs.
REQ-008 SHALL have port sync_o  output  WIDTH_P  raw synchronizer output, last stage.
REQ-009 SHALL have port level_o  output  WIDTH_P  filtered, registered channel level.
REQ-010 SHALL have port rise_o  output  WIDTH_P  one-cycle pulse per channel on level_o 0->1.
REQ-011 SHALL have port fall_o  output  WIDTH_P  one-cycle pulse per channel on level_o 1->0.
REQ-012 SHALL have port busy_o  output  1  high while any channel debounce counter is nonzero.

Function
REQ-013 Each channel SHALL pass through STAGES_P flops; sync_o SHALL follow a stable async_i change after exactly STAGES_P rising edges.
REQ-014 Channels SHALL be fully independent; no cross-channel logic except the busy_o OR-reduction.
REQ-015 Per-channel counter, width $clog2(FILT_CYC_P+1): cleared when sync_o bit equals level_o bit; incremented when they differ.
REQ-016 When the bit differs and counter equals FILT_CYC_P-1, level_o bit SHALL toggle on the next edge and the counter SHALL clear.
REQ-017 Hence level_o SHALL change at edge T+FILT_CYC_P when sync_o differs from level_o on every cycle T..T+FILT_CYC_P-1; any earlier return to equality SHALL cancel the change.
REQ-018 rise_o/fall_o SHALL be registered, asserted on the same edge level_o changes, for exactly one cycle; never both high on one channel.
REQ-019 A pulse longer than STAGES_P+FILT_CYC_P cycles SHALL always produce exactly one rise and one fall; a sync_o glitch shorter than FILT_CYC_P cycles SHALL produce none.
REQ-020 Counter SHALL never wrap; it saturates at FILT_CYC_P-1 by construction of REQ-016.
REQ-021 busy_o SHALL be the registered-state OR of all nonzero counters, no extra latency.

Reset
REQ-022 While rstn_i low: all synchronizer stages and level_o = RESET_VAL_P; counters, rise_o, fall_o, busy_o = 0.
REQ-023 Reset assertion mid-debounce SHALL abort it with no pulse emitted.
REQ-024 After release, with async_i equal to RESET_VAL_P, no rise_o/fall_o SHALL occur.

Configuration
REQ-025 Macro SYNC_FILT_DEBOUNCE_EN defined: behaviour per REQ-015..REQ-021.
REQ-026 Macro undefined: counters removed; level_o SHALL register sync_o (one-cycle latency, equal to FILT_CYC_P=1); busy_o tied 0; FILT_CYC_P ignored.

Structure
REQ-027 Package sync_pkg SHALL hold the counter-width function and parameter-range limit constants (STAGES_MIN/MAX, FILT_CYC_MAX).
REQ-028 Sub-module sync_filt_bit SHALL implement one channel's counter, level and edge flops; the top generates WIDTH_P instances plus the synchronizer array.
REQ-029 Elaboration SHALL fail for STAGES_P or FILT_CYC_P outside legal range.

Verification
REQ-030 Reset: RESET_VAL_P=8'hA5, async_i=8'hA5, release rstn_i -> level_o=8'hA5, no rise_o/fall_o for 20 cycles.
REQ-031 Latency: STAGES_P=2, FILT_CYC_P=4, async_i[0] 0->1 held -> sync_o[0] rises after 2 edges, level_o[0] and rise_o[0] 4 edges later, rise_o one cycle.
REQ-032 Glitch: async_i[3] high 3 cycles, FILT_CYC_P=4 -> busy_o high, no level_o/rise_o change, busy_o returns 0.
REQ-033 Independence: channels 1 and 6 toggle opposite directions same cycle -> rise_o[1] and fall_o[6] coincide, others quiet.
REQ-034 Reset mid-debounce: assert rstn_i 2 cycles into a 4-cycle filter -> no pulse, level_o=RESET_VAL_P.
REQ-035 Macro off: same stimulus as REQ-031 -> level_o follows sync_o by 1 cycle, busy_o constant 0.
